// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR complex-multiply datapath.
package fir_pkg;

    localparam int unsigned FIR_DATA_WIDTH  = 16;
    localparam int unsigned FIR_SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        FIR_CM_AB    = 2'b00,
        FIR_CM_CONJA = 2'b01,
        FIR_CM_CONJB = 2'b10
    } FIR_CONJ_MODE;

    typedef struct packed {
        logic signed [FIR_DATA_WIDTH-1:0] data_r;
        logic signed [FIR_DATA_WIDTH-1:0] data_i;
    } fir_sample_t;

    // Raw 2'b11 has no meaning of its own and folds onto conj(A)*B.
    function automatic FIR_CONJ_MODE fir_decode_mode(input logic [1:0] raw);
        case (raw)
            2'b00:   return FIR_CM_AB;
            2'b10:   return FIR_CM_CONJB;
            default: return FIR_CM_CONJA;
        endcase
    endfunction

endpackage

// File: rtl/fir_shift_rnd_sat.sv
// Single-rail arithmetic right shift, optional round-half-up, saturate to DATA_W.
// Rounding is enabled by defining FIR_CMULT_ROUND_EN; otherwise the shift truncates.
module fir_shift_rnd_sat #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic signed [2*DATA_W:0]  sum,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DATA_W-1:0]  res,
    output logic                      clip
);

    localparam int unsigned SW = 2 * DATA_W + 1;
    localparam int unsigned WW = SW + 1;
    localparam logic signed [DATA_W-1:0] MaxV = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MinV = {1'b1, {(DATA_W - 1){1'b0}}};

    logic signed [WW-1:0] wide;
    logic signed [WW-1:0] shifted;
    logic        [31:0]   shamt;
    logic                 big;

    always_comb begin
        shamt = 32'(shift);
        big   = shamt >= 32'(2 * DATA_W);
        wide  = WW'(sum);
`ifdef FIR_CMULT_ROUND_EN
        // One guard bit above the sum keeps the rounding add from wrapping.
        if (shamt != 32'd0 && !big) begin
            wide = wide + (WW'(1) << (shamt - 32'd1));
        end
`endif
        shifted = wide >>> shamt;
        clip    = 1'b0;
        res     = shifted[DATA_W-1:0];
        if (big) begin
`ifdef FIR_CMULT_ROUND_EN
            res = '0;
`else
            res = sum[SW-1] ? '1 : '0;
`endif
        end else if (shifted[WW-1:DATA_W-1] != {(WW - DATA_W + 1){shifted[DATA_W-1]}}) begin
            clip = 1'b1;
            res  = shifted[WW-1] ? MinV : MaxV;
        end
    end

endmodule

// File: rtl/fir_cmult_stream.sv
// Streaming complex multiplier (A*B, conj(A)*B, A*conj(B)) with stall, shift and saturation.
// Define FIR_CMULT_ROUND_EN for round-half-up scaling; default build truncates.
module fir_cmult_stream
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = FIR_DATA_WIDTH,
    parameter int unsigned SHIFT_W   = FIR_SHIFT_WIDTH,
    parameter int unsigned MULT_PIPE = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  opa_r,
    input  logic signed [DATA_W-1:0]  opa_i,
    input  logic signed [DATA_W-1:0]  opb_r,
    input  logic signed [DATA_W-1:0]  opb_i,
    input  logic        [1:0]         conj_mode,
    input  logic        [SHIFT_W-1:0] shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_r,
    output logic signed [DATA_W-1:0]  out_i,
    output logic                      sat_flag,
    output logic        [CNT_W-1:0]   sat_count,
    input  logic                      clr_sat
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = 2 * DATA_W + 1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic                      src_valid;
    logic signed [DATA_W-1:0]  src_ar, src_ai, src_br, src_bi;
    FIR_CONJ_MODE              src_mode;
    logic        [SHIFT_W-1:0] src_shift;

    if (MULT_PIPE != 0) begin : g_mpipe
        logic                      m_valid;
        logic signed [DATA_W-1:0]  m_ar, m_ai, m_br, m_bi;
        FIR_CONJ_MODE              m_mode;
        logic        [SHIFT_W-1:0] m_shift;

        always_ff @(posedge clk) begin
            if (rst) begin
                m_valid <= 1'b0;
            end else if (en) begin
                m_valid <= in_valid;
                m_ar    <= opa_r;
                m_ai    <= opa_i;
                m_br    <= opb_r;
                m_bi    <= opb_i;
                m_mode  <= fir_decode_mode(conj_mode);
                m_shift <= shift;
            end
        end

        assign src_valid = m_valid;
        assign src_ar    = m_ar;
        assign src_ai    = m_ai;
        assign src_br    = m_br;
        assign src_bi    = m_bi;
        assign src_mode  = m_mode;
        assign src_shift = m_shift;
    end else begin : g_nopipe
        assign src_valid = in_valid;
        assign src_ar    = opa_r;
        assign src_ai    = opa_i;
        assign src_br    = opb_r;
        assign src_bi    = opb_i;
        assign src_mode  = fir_decode_mode(conj_mode);
        assign src_shift = shift;
    end

    // Stage 1: raw products.
    logic                      s1_valid;
    logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
    FIR_CONJ_MODE              s1_mode;
    logic        [SHIFT_W-1:0] s1_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= src_valid;
            p_rr     <= PW'(src_ar) * PW'(src_br);
            p_ii     <= PW'(src_ai) * PW'(src_bi);
            p_ri     <= PW'(src_ar) * PW'(src_bi);
            p_ir     <= PW'(src_ai) * PW'(src_br);
            s1_mode  <= src_mode;
            s1_shift <= src_shift;
        end
    end

    // Stage 2: combine, scale, saturate.
    logic signed [SW-1:0]     rr, ii, ri, ir;
    logic signed [SW-1:0]     sum_re, sum_im;
    logic signed [DATA_W-1:0] res_re, res_im;
    logic                     clip_re, clip_im;

    always_comb begin
        rr     = SW'(p_rr);
        ii     = SW'(p_ii);
        ri     = SW'(p_ri);
        ir     = SW'(p_ir);
        sum_re = rr - ii;
        sum_im = ri + ir;
        case (s1_mode)
            FIR_CM_CONJA: begin
                sum_re = rr + ii;
                sum_im = ri - ir;
            end
            FIR_CM_CONJB: begin
                sum_re = rr + ii;
                sum_im = ir - ri;
            end
            default: ;
        endcase
    end

    fir_shift_rnd_sat #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_rail_re (
        .sum   (sum_re),
        .shift (s1_shift),
        .res   (res_re),
        .clip  (clip_re)
    );

    fir_shift_rnd_sat #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_rail_im (
        .sum   (sum_im),
        .shift (s1_shift),
        .res   (res_im),
        .clip  (clip_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_r    <= res_re;
                out_i    <= res_im;
                sat_flag <= clip_re || clip_im;
            end
        end
    end

    // Counts accepted saturated beats; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_sat) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat_flag && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_cmult_stream.sv
// Directed self-checking bench for fir_cmult_stream (MULT_PIPE=1, CNT_W=4).
module tb_fir_cmult_stream;

    localparam int MP  = 1;
    localparam int LAT = 2 + MP;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] opa_r = '0, opa_i = '0, opb_r = '0, opb_i = '0;
    logic        [1:0]  conj_mode = '0;
    logic        [4:0]  shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_r, out_i;
    logic               sat_flag;
    logic        [3:0]  sat_count;
    logic               clr_sat = 1'b0;

    always #5 clk = ~clk;

    fir_cmult_stream #(
        .DATA_W    (16),
        .SHIFT_W   (5),
        .MULT_PIPE (MP),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa_r     (opa_r),
        .opa_i     (opa_i),
        .opb_r     (opb_r),
        .opb_i     (opb_i),
        .conj_mode (conj_mode),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .sat_flag  (sat_flag),
        .sat_count (sat_count),
        .clr_sat   (clr_sat)
    );

    typedef struct {
        logic signed [15:0] r;
        logic signed [15:0] i;
        logic               sf;
    } exp_t;

    exp_t eq[$];
    int   total = 0;
    int   bad = 0;
    int   popped = 0;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Every visible output beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (eq.size() == 0) begin
                check("stale_beat", longint'(out_valid), 0);
            end else begin
                check("out_r", out_r, eq[0].r);
                check("out_i", out_i, eq[0].i);
                check("sat_flag", longint'(sat_flag), longint'(eq[0].sf));
                if (out_ready) begin
                    void'(eq.pop_front());
                    popped++;
                end else begin
                    check("stall_in_ready", longint'(in_ready), 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int m, input int sh,
                        input int er, input int ei, input int esf);
        int   n;
        exp_t e;
        opa_r     = 16'(ar);
        opa_i     = 16'(ai);
        opb_r     = 16'(br);
        opb_i     = 16'(bi);
        conj_mode = 2'(m);
        shift     = 5'(sh);
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", n, 0);
        @(posedge clk);
        e.r  = 16'(er);
        e.i  = 16'(ei);
        e.sf = esf[0];
        eq.push_back(e);
        #1;
    endtask

    task automatic send_lat(input int m, input int er, input int ei);
        int cnt;
        send(3, 4, 5, -2, m, 0, er, ei, 0);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", cnt, LAT);
        idle(2);
    endtask

    function automatic int ref_re(input int ar, input int ai, input int br, input int bi,
                                  input int m);
        return (m == 0) ? ar * br - ai * bi : ar * br + ai * bi;
    endfunction

    function automatic int ref_im(input int ar, input int ai, input int br, input int bi,
                                  input int m);
        if (m == 0) return ar * bi + ai * br;
        if (m == 2) return ai * br - ar * bi;
        return ar * bi - ai * br;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        check("rst_sat_count", longint'(sat_count), 0);
        check("rst_in_ready", longint'(in_ready), 1);

        // Conjugation modes, including the 11 alias.
        send_lat(0, 23, 14);
        send_lat(1, 7, -26);
        send_lat(2, 7, 26);
        send_lat(3, 7, -26);

        // Saturation and large shifts.
        send(-32768, 0, -32768, 0, 0, 0, 32767, 0, 1);
        in_valid = 1'b0;
        idle(LAT + 2);
        check("sat_count_1", longint'(sat_count), 1);
        send(-32768, 0, -32768, 0, 0, 15, 32767, 0, 1);
        send(-32768, 0, -32768, 0, 0, 16, 16384, 0, 0);
        in_valid = 1'b0;
        idle(LAT + 2);
        check("sat_count_2", longint'(sat_count), 2);

        // Rounding versus truncation.
`ifdef FIR_CMULT_ROUND_EN
        send(3, 0, 1, 0, 0, 1, 2, 0, 0);
        send(-3, 0, 1, 0, 0, 1, -1, 0, 0);
`else
        send(3, 0, 1, 0, 0, 1, 1, 0, 0);
        send(-3, 0, 1, 0, 0, 1, -2, 0, 0);
`endif
        in_valid = 1'b0;
        idle(LAT + 2);

        // 20-beat stream with a downstream stall.
        popped = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    send(k + 1, -k, 2, 3, k % 3, 0,
                         ref_re(k + 1, -k, 2, 3, k % 3), ref_im(k + 1, -k, 2, 3, k % 3), 0);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 5 && c <= 9);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(LAT + 4);
        check("stream_count", popped, 20);
        check("stream_left", eq.size(), 0);

        // Reset with beats in flight.
        send(1, 1, 1, 1, 0, 0, 0, 2, 0);
        send(2, 2, 2, 2, 0, 0, 0, 8, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        eq.delete();
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_sat_count", longint'(sat_count), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        for (int n = 0; n < 6; n++) begin
            check("midrst_no_stale", longint'(out_valid), 0);
            idle(1);
        end

        // Counter sticks at all-ones; clear beats a same-cycle increment.
        for (int k = 0; k < 16; k++) send(-32768, 0, -32768, 0, 0, 0, 32767, 0, 1);
        in_valid = 1'b0;
        idle(LAT + 2);
        check("sat_count_stick", longint'(sat_count), 15);
        send(-32768, 0, -32768, 0, 0, 0, 32767, 0, 1);
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) idle(1);
        check("clr_wait_valid", longint'(out_valid), 1);
        clr_sat = 1'b1;
        idle(1);
        clr_sat = 1'b0;
        check("sat_count_clr", longint'(sat_count), 0);
        idle(3);
        check("final_left", eq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_cmult_stream.md
Name: fir_cmult_stream

Overview:
Parametrised streaming complex multiplier for the FIR datapath, generalising the fixed conj(A)*B unit. Adds a runtime conjugation mode, valid/ready flow control with stall, a configurable pipeline depth, round-or-truncate scaling and saturation monitoring. Sits between the tap-coefficient fetch and the accumulator in the FIR engine.

Parameters:
DATA_W, 16, signed width of each real/imag rail (in and out)
SHIFT_W, 5, width of the right-shift control
MULT_PIPE, 0, 0 or 1; 1 adds an input register stage before the multipliers
CNT_W, 16, width of the saturation event counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
opa_r, opa_i  in  DATA_W each  operand A, signed
opb_r, opb_i  in  DATA_W each  operand B, signed
conj_mode  in  2  00 A*B, 01 conj(A)*B, 10 A*conj(B), 11 treated as 01; sampled with the beat
shift  in  SHIFT_W  arithmetic right shift applied to the product; sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_r, out_i  out  DATA_W each  result, signed, saturated
sat_flag  out  1  either rail of this output beat saturated; aligned with out_*
sat_count  out  CNT_W  accepted output beats with sat_flag=1; sticks at all-ones
clr_sat  in  1  clear sat_count

Behaviour:
- Reset: out_valid=0, out_r=out_i=0, sat_flag=0, sat_count=0, all stage valids=0. Reset mid-stream drops all in-flight beats. in_ready=1 in the first cycle after reset.
- Global enable en = !out_valid || out_ready. in_ready = en, combinational. All stages advance only when en=1. Bubbles are not collapsed.
- Latency: LATENCY = 2 + MULT_PIPE cycles from input handshake to out_valid when there is no stall. Throughput is one beat per cycle.
- Stage M (when MULT_PIPE=1): registers the operands, conj_mode and shift.
- Stage 1: registers four full 2*DATA_W signed products (ar*br, ai*bi, ar*bi, ai*br) plus mode and shift.
- Stage 2 sums at 2*DATA_W+1 bits:
  - 00: re = ar*br - ai*bi, im = ar*bi + ai*br
  - 01: re = ar*br + ai*bi, im = ar*bi - ai*br
  - 10: re = ar*br + ai*bi, im = ai*br - ar*bi
- Stage 2 then shifts each sum arithmetically right by shift and rounds per the Optional Feature.
- Saturation: the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. sat_flag = either rail clipped. Out registers are written in stage 2.
- A shift value of 2*DATA_W or more yields 0, or -1 for a negative sum under truncation, with no saturation.
- Stall: while out_valid && !out_ready, out_* and all pipeline contents hold bit-exact and in_ready=0. No beat is lost or duplicated.
- sat_count increments on a handshake (out_valid && out_ready) with sat_flag=1 and sticks at 2^CNT_W-1. clr_sat takes priority over a same-cycle increment; the result is 0.
- Fully synchronous; no latches; no combinational path from in_valid to out_*.

Optional Feature:
Macro FIR_CMULT_ROUND_EN.
- Defined: round-half-up. Add 2^(shift-1) before the shift when shift>0. The add is done at 2*DATA_W+2 bits, so it never overflows internally.
- Undefined: plain truncation (floor).
- Latency and interface are identical in both builds.

Decomposition:
- fir_pkg holds:
  - enum FIR_CONJ_MODE {FIR_CM_AB, FIR_CM_CONJA, FIR_CM_CONJB}
  - FIR_DATA_WIDTH and FIR_SHIFT width constants as the defaults for DATA_W/SHIFT_W
  - sample struct (data_r, data_i) for the DATA_W=FIR_DATA_WIDTH wrapper
- One sub-module, fir_shift_rnd_sat: single-rail shift, round and saturate from 2*DATA_W+1 bits to DATA_W bits with a clip flag. It is instantiated twice, once per rail.

Test Plan:
1. DATA_W=16, shift=0, out_ready=1, A=(3,4), B=(5,-2). Expected out_valid 2 cycles later (3 with MULT_PIPE=1):
   - mode 00 -> (23,14)
   - mode 01 -> (7,-26)
   - mode 10 -> (7,26)
   - mode 11 -> (7,-26)
2. A=(-32768,0), B=(-32768,0), mode 00:
   - shift=0 -> out_r=32767, sat_flag=1, sat_count=1
   - shift=15 -> 32767, sat_flag=1
   - shift=16 -> 16384, sat_flag=0
3. A=(3,0), B=(1,0), shift=1:
   - ROUND_EN -> out_r=2; A=(-3,0) -> -1
   - without the macro -> 1 and -2
4. Back-to-back stream of 20 distinct beats, out_ready low for cycles 5-9:
   - in_ready low during the stall, out_* stable
   - all 20 results emerge in order, exactly once
5. Pulse rst while 2 beats are in flight -> out_valid=0 next cycle, sat_count=0, no stale beat later.
6. Force sat_count to all-ones with CNT_W=4 (16 saturating beats) -> holds at 15. Assert clr_sat together with a saturating handshake -> 0.
